// File: rtl/pl_debug_led_pkg.sv
// Shared types and register field positions for the PL debug LED driver.
package pl_debug_led_pkg;

  typedef enum logic [1:0] {
    LED_STATIC = 2'd0,
    LED_BLINK  = 2'd1,
    LED_PWM    = 2'd2,
    LED_EVENT  = 2'd3
  } led_mode_t;

  localparam int unsigned CTRL_EN_BIT  = 31;
  localparam int unsigned CTRL_CLR_BIT = 30;
  localparam int unsigned REG_W        = 32;
  localparam int unsigned MODE_W       = 2;
  localparam int unsigned DUTY_LANE_W  = 8;

endpackage

// File: rtl/pl_debug_led_channel.sv
// One LED channel: mode mux, blink phase, event stretch, PWM compare, output flop.
// Define PL_DEBUG_LED_GAMMA_EN for a square-law PWM duty curve.
module pl_debug_led_channel
  import pl_debug_led_pkg::*;
#(
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned STRETCH_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic             static_val,
  input  logic [PWM_W-1:0] duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             tick,
  input  logic             evt,
  output logic             led
);

  localparam int unsigned SW = $clog2(STRETCH_TICKS + 1);

  led_mode_t       mode_e;
  logic            phase;
  logic [SW-1:0]   stretch;
  logic [PWM_W-1:0] duty_eff;
  logic            led_next;

  assign mode_e = led_mode_t'(mode);

`ifdef PL_DEBUG_LED_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;
  assign duty_sq  = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, duty};
  assign duty_eff = duty_sq[2*PWM_W-1:PWM_W];
`else
  assign duty_eff = duty;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      stretch <= '0;
      led     <= 1'b0;
    end else begin
      if (!run || mode_e != LED_BLINK)
        phase <= 1'b0;
      else if (tick)
        phase <= ~phase;

      // An event coinciding with a tick reloads rather than decrements.
      if (!run || mode_e != LED_EVENT)
        stretch <= '0;
      else if (evt)
        stretch <= SW'(STRETCH_TICKS);
      else if (tick && stretch != '0)
        stretch <= stretch - SW'(1);

      led <= led_next;
    end
  end

  always_comb begin
    led_next = 1'b0;
    if (run) begin
      case (mode_e)
        LED_STATIC: led_next = static_val;
        LED_BLINK:  led_next = phase;
        LED_PWM:    led_next = (pwm_cnt < duty_eff);
        LED_EVENT:  led_next = (stretch != '0);
        default:    led_next = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/pl_debug_led_driver.sv
// PL debug LED driver: shared prescaler, PWM counter and enable/clear gating over per-LED channels.
// Define PL_DEBUG_LED_GAMMA_EN for a square-law PWM duty curve in every channel.
module pl_debug_led_driver
  import pl_debug_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned PRESCALE_W    = 24,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned STRETCH_TICKS = 4
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [REG_W-1:0]    reg_ctrl,
  input  logic [REG_W-1:0]    reg_mode,
  input  logic [REG_W-1:0]    reg_period,
  input  logic [REG_W-1:0]    reg_duty,
  input  logic                cfg_update,
  input  logic [NUM_LEDS-1:0] evt_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                tick_out
);

  logic                  run;
  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PWM_W-1:0]      pwm_cnt;
  logic                  tick_now;
  logic                  unused_regs;

  assign run         = reg_ctrl[CTRL_EN_BIT] & ~reg_ctrl[CTRL_CLR_BIT];
  assign period      = reg_period[PRESCALE_W-1:0];
  assign tick_now    = run & ~cfg_update & (period != '0) & (presc_cnt == period);
  assign unused_regs = ^{reg_ctrl, reg_mode, reg_period, reg_duty};

  // A register write restarts the prescaler so a shrunk period never waits for wrap.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      tick_out  <= 1'b0;
    end else begin
      if (!run || cfg_update || period == '0 || presc_cnt == period)
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + PRESCALE_W'(1);

      if (!run)
        pwm_cnt <= '0;
      else
        pwm_cnt <= pwm_cnt + PWM_W'(1);

      tick_out <= tick_now;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    pl_debug_led_channel #(
      .PWM_W         (PWM_W),
      .STRETCH_TICKS (STRETCH_TICKS)
    ) u_chan (
      .clk        (ACLK),
      .rst_n      (ARESETN),
      .run        (run),
      .mode       (reg_mode[MODE_W*i +: MODE_W]),
      .static_val (reg_ctrl[i]),
      .duty       (reg_duty[DUTY_LANE_W*i +: PWM_W]),
      .pwm_cnt    (pwm_cnt),
      .tick       (tick_now),
      .evt        (evt_in[i]),
      .led        (led_out[i])
    );
  end

endmodule

// File: tb/tb_pl_debug_led_driver.sv
// Directed self-checking bench for pl_debug_led_driver (PL_DEBUG_LED_GAMMA_EN aware).
module tb_pl_debug_led_driver;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] reg_ctrl = '0;
  logic [31:0] reg_mode = '0;
  logic [31:0] reg_period = '0;
  logic [31:0] reg_duty = '0;
  logic        cfg_update = 1'b0;
  logic [3:0]  evt_in = '0;
  logic [3:0]  led_out;
  logic        tick_out;

  int checks = 0;
  int errors = 0;

  pl_debug_led_driver #(
    .NUM_LEDS      (4),
    .PRESCALE_W    (24),
    .PWM_W         (8),
    .STRETCH_TICKS (4)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .reg_ctrl   (reg_ctrl),
    .reg_mode   (reg_mode),
    .reg_period (reg_period),
    .reg_duty   (reg_duty),
    .cfg_update (cfg_update),
    .evt_in     (evt_in),
    .led_out    (led_out),
    .tick_out   (tick_out)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic test_reset();
    ARESETN    = 1'b0;
    reg_ctrl   = 32'hFFFF_FFFF;
    reg_mode   = 32'h5555_5555;
    reg_period = 32'h0000_0003;
    reg_duty   = 32'hFFFF_FFFF;
    evt_in     = 4'hF;
    cfg_update = 1'b1;
    repeat (20) begin
      @(negedge ACLK);
      checks++;
      if (led_out !== 4'b0000) begin
        errors++;
        $display("FAIL reset_led: got %b expected 0000", led_out);
      end
      checks++;
      if (tick_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_tick: got %b expected 0", tick_out);
      end
    end
    reg_ctrl   = 32'h8000_0005;
    reg_mode   = '0;
    reg_period = '0;
    reg_duty   = '0;
    evt_in     = '0;
    cfg_update = 1'b0;
    ARESETN    = 1'b1;
    @(negedge ACLK);
    checks++;
    if (led_out !== 4'b0101) begin
      errors++;
      $display("FAIL reset_release_static: got %b expected 0101", led_out);
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp_led;
    reg_ctrl   = 32'h8000_0000;
    reg_mode   = 32'h0000_0001;
    reg_period = 32'd9;
    cfg_update = 1'b1;
    @(negedge ACLK);
    cfg_update = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge ACLK);
      exp_led = {3'b000, ((((k - 1) / 10) % 2) == 1)};
      checks++;
      if (tick_out !== (k % 10 == 0)) begin
        errors++;
        $display("FAIL blink_tick k=%0d: got %b expected %b", k, tick_out, (k % 10 == 0));
      end
      checks++;
      if (led_out !== exp_led) begin
        errors++;
        $display("FAIL blink_led k=%0d: got %b expected %b", k, led_out, exp_led);
      end
    end
    reg_period = '0;
    cfg_update = 1'b1;
    @(negedge ACLK);
    cfg_update = 1'b0;
    repeat (30) begin
      @(negedge ACLK);
      checks++;
      if (led_out !== 4'b0001 || tick_out !== 1'b0) begin
        errors++;
        $display("FAIL blink_hold: got led %b tick %b expected led 0001 tick 0", led_out, tick_out);
      end
    end
  endtask

  task automatic test_pwm();
    int duties [4] = '{64, 0, 255, 128};
`ifdef PL_DEBUG_LED_GAMMA_EN
    int expect_hi [4] = '{16, 0, 254, 64};
`else
    int expect_hi [4] = '{64, 0, 255, 128};
`endif
    int hi;
    for (int t = 0; t < 4; t++) begin
      reg_ctrl   = 32'h8000_0000;
      reg_mode   = 32'h0000_0002;
      reg_duty   = 32'(duties[t]);
      cfg_update = 1'b1;
      @(negedge ACLK);
      cfg_update = 1'b0;
      repeat (3) @(negedge ACLK);
      hi = 0;
      repeat (256) begin
        @(negedge ACLK);
        if (led_out[0]) hi++;
      end
      checks++;
      if (hi !== expect_hi[t]) begin
        errors++;
        $display("FAIL pwm_duty%0d: got %0d high cycles expected %0d", duties[t], hi, expect_hi[t]);
      end
      checks++;
      if (led_out[3:1] !== 3'b000) begin
        errors++;
        $display("FAIL pwm_other_leds: got %b expected 000", led_out[3:1]);
      end
    end
  endtask

  task automatic test_event();
    logic [3:0] exp_led;
    reg_ctrl   = 32'h8000_0000;
    reg_mode   = 32'h0000_0003;
    reg_period = 32'd4;
    reg_duty   = '0;
    cfg_update = 1'b1;
    @(negedge ACLK);
    cfg_update = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge ACLK);
      exp_led = {3'b000, (k >= 3 && k <= 35)};
      checks++;
      if (tick_out !== (k % 5 == 0)) begin
        errors++;
        $display("FAIL event_tick k=%0d: got %b expected %b", k, tick_out, (k % 5 == 0));
      end
      checks++;
      if (led_out !== exp_led) begin
        errors++;
        $display("FAIL event_led k=%0d: got %b expected %b", k, led_out, exp_led);
      end
      // k=14 pulse lands on the tick edge: retrigger must win over decrement.
      evt_in = (k == 1) ? 4'b0011 : (k == 14) ? 4'b0001 : 4'b0000;
    end
    evt_in = '0;
  endtask

  task automatic test_gating();
    logic [3:0] exp_led;
    reg_ctrl   = 32'h8000_0000;
    reg_mode   = 32'h0000_0001;
    reg_period = 32'd9;
    cfg_update = 1'b1;
    @(negedge ACLK);
    cfg_update = 1'b0;
    repeat (15) @(negedge ACLK);
    reg_ctrl = 32'h0000_0000;
    repeat (5) begin
      @(negedge ACLK);
      checks++;
      if (led_out !== 4'b0000 || tick_out !== 1'b0) begin
        errors++;
        $display("FAIL gate_off: got led %b tick %b expected led 0000 tick 0", led_out, tick_out);
      end
    end
    reg_ctrl = 32'h8000_0000;
    for (int j = 1; j <= 12; j++) begin
      @(negedge ACLK);
      exp_led = {3'b000, (j >= 11)};
      checks++;
      if (tick_out !== (j == 10) || led_out !== exp_led) begin
        errors++;
        $display("FAIL gate_restart j=%0d: got led %b tick %b expected led %b tick %b",
                 j, led_out, tick_out, exp_led, (j == 10));
      end
    end
    reg_ctrl = 32'hC000_0000;
    repeat (15) begin
      @(negedge ACLK);
      checks++;
      if (led_out !== 4'b0000 || tick_out !== 1'b0) begin
        errors++;
        $display("FAIL soft_clear: got led %b tick %b expected led 0000 tick 0", led_out, tick_out);
      end
    end
    reg_ctrl = 32'h8000_0000;
    for (int j = 1; j <= 21; j++) begin
      @(negedge ACLK);
      exp_led = {3'b000, (j >= 21)};
      checks++;
      if (tick_out !== (j == 20) || led_out !== exp_led) begin
        errors++;
        $display("FAIL cfg_at_terminal j=%0d: got led %b tick %b expected led %b tick %b",
                 j, led_out, tick_out, exp_led, (j == 20));
      end
      cfg_update = (j == 9);
    end
    cfg_update = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    reg_ctrl   = 32'h8000_0000;
    reg_mode   = 32'h0000_0002;
    reg_duty   = 32'h0000_00FF;
    cfg_update = 1'b1;
    @(negedge ACLK);
    cfg_update = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ACLK);
      if (led_out[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL async_wait_high: got led %b expected led0 high within 20 cycles", led_out);
    end
    #2 ARESETN = 1'b0;
    #1;
    checks++;
    if (led_out !== 4'b0000 || tick_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop: got led %b tick %b expected led 0000 tick 0", led_out, tick_out);
    end
    @(negedge ACLK);
    checks++;
    if (led_out !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_hold: got %b expected 0000", led_out);
    end
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  initial begin
    test_reset();
    test_blink();
    test_pwm();
    test_event();
    test_gating();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pl_debug_led_driver.md
Name: pl_debug_led_driver

Overview:
- Downstream consumer of the PL debug LED controller's AXI4-Lite register file (4 x 32-bit slave registers).
- Turns the register words plus fabric event pulses into per-LED drive: static, blink, PWM dim, or event pulse-stretch.
- `led_out` goes to the PL debug LED pins.
- Purely a fabric-side stage with no AXI logic.

Parameters:
- NUM_LEDS, 4, number of LED channels (1..4; mode and duty fields are packed per LED).
- PRESCALE_W, 24, width of the blink/stretch prescaler counter.
- PWM_W, 8, PWM counter and duty width.
- STRETCH_TICKS, 4, prescaler ticks an event keeps its LED lit.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  asynchronous active-low reset.
- reg_ctrl  in  32  slv_reg0:
  - [31] global enable
  - [30] soft clear
  - [NUM_LEDS-1:0] static LED values
- reg_mode  in  32  slv_reg1; [2i+1:2i] selects LED i mode.
- reg_period  in  32  slv_reg2; [PRESCALE_W-1:0] prescaler terminal count.
- reg_duty  in  32  slv_reg3; [8i+PWM_W-1:8i] duty for LED i.
- cfg_update  in  1  one-cycle pulse when any register is written.
- evt_in  in  NUM_LEDS  per-LED one-cycle event pulses.
- led_out  out  NUM_LEDS  registered LED drive.
- tick_out  out  1  one-cycle prescaler tick, for debug.

Behaviour:
- Reset: ARESETN low asynchronously clears `led_out`, `tick_out`, the prescaler, the PWM counter, all blink phases and all stretch counters to 0.
- Prescaler:
  - Counts ACLK cycles 0..P, where P = reg_period[PRESCALE_W-1:0].
  - At count == P: `tick_out` = 1 for one cycle and the count returns to 0.
  - P == 0: no ticks at all; the prescaler holds at 0.
  - cfg_update = 1: prescaler reloads 0 that cycle, with no tick, even if count == P.
- PWM counter: free-running PWM_W bits, increments every cycle, wraps from 2^PWM_W-1 to 0.
- Mode 0 STATIC: LED i = reg_ctrl[i].
- Mode 1 BLINK:
  - Per-LED phase flop toggles on each tick; LED = phase.
  - P == 0 holds the phase.
  - Phase clears whenever the LED is in any other mode.
- Mode 2 PWM:
  - LED = (pwm_cnt < duty_i).
  - duty 0 means always off; duty 255 means on 255 of 256 cycles.
- Mode 3 EVENT:
  - evt_in[i] loads stretch_i = STRETCH_TICKS.
  - Each tick decrements a nonzero stretch_i.
  - LED = (stretch_i != 0).
  - Event in the same cycle as a tick: the load wins (retrigger, no decrement).
  - Events in other modes are ignored.
- Global gate:
  - reg_ctrl[31] = 0 forces `led_out` = 0 and holds the prescaler, PWM counter, phases and stretch counters at 0.
  - Re-enable starts everything from 0.
- Soft clear: reg_ctrl[30] = 1 synchronously clears all counters/phases every cycle it is held; `led_out` = 0 while held.
- Latency: `led_out` is registered, so the output reflects the state/inputs one ACLK after the internal decision.
  - Example: STATIC reg_ctrl change appears on `led_out` 1 cycle later.
  - Example: evt_in at cycle n gives LED high at n+2 (stretch load at n+1, output flop at n+2).
- Register changes mid-operation:
  - Mode changes take effect next cycle.
  - The blink phase restarts at 0 on entry to BLINK.
  - A P reduction below the current count does not wait for wrap, because cfg_update reloads the prescaler.
- Reset mid-operation: ARESETN assertion drops `led_out` to 0 immediately (asynchronous) and the bench sees no stale tick.

Optional Feature:
- Macro: PL_DEBUG_LED_GAMMA_EN.
- Defined: PWM compare uses duty_eff = (duty*duty) >> PWM_W, a square-law perceptual curve, computed combinationally per channel.
  - duty 128 yields 64; duty 255 yields 254.
- Undefined: duty_eff = duty (linear).
- All other behaviour is identical.

Decomposition:
- Package `pl_debug_led_pkg`:
  - `led_mode_t` enum: LED_STATIC = 2'd0, LED_BLINK = 2'd1, LED_PWM = 2'd2, LED_EVENT = 2'd3.
  - Bit-position constants CTRL_EN_BIT = 31, CTRL_CLR_BIT = 30.
  - Field-width constants.
- Sub-module `pl_debug_led_channel`, instantiated NUM_LEDS times via generate:
  - Per-LED mode mux, blink phase, stretch counter, PWM compare (with gamma option) and output flop.
- The top holds the shared prescaler, the PWM counter and the enable/clear gating.

Test Plan:
- Reset: ARESETN = 0 for 20 cycles, all register inputs nonzero → `led_out` = 0 and `tick_out` = 0 throughout; after release with reg_ctrl = 0x8000_0005, mode = 0 → `led_out` = 4'b0101 one cycle after the first enabled edge.
- Blink: reg_ctrl = 0x8000_0000, reg_mode = 0x01, reg_period = 9 → `tick_out` every 10 cycles; led_out[0] toggles every 10 cycles (20-cycle period); set period = 0 → toggling stops and the level holds.
- PWM: mode = 0x02, duty0 = 64, gamma undefined → led_out[0] high exactly 64 of every 256 cycles; duty = 0 → never high; duty = 255 → 255/256; with PL_DEBUG_LED_GAMMA_EN and duty = 128 → 64/256.
- Event stretch: mode = 0x03, period = 4, evt_in[0] pulse → LED high 2 cycles later and drops after 4 ticks (about 20 cycles); a second pulse coinciding with a tick → reload to 4, no decrement.
- Gating: mid-blink, clear reg_ctrl[31] → `led_out` = 0 next cycle and counters are 0; set reg_ctrl[30] while enabled → output 0 while held; cfg_update with count == P → no tick, prescaler restarts at 0.
- Async reset mid-operation: assert ARESETN off-edge during PWM-high → `led_out` falls before the next ACLK edge.
